// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 8-to-1 mux.
// Each owner holds the grant for at most MAX_BURST consecutive cycles.
module mux8_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid,
  output logic       burst_done
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        gnt_n;
  logic [2:0]        sel_n;
  logic              done_n;

  logic [15:0]       dbl;
  logic [7:0]        rot;
  logic [2:0]        off;
  logic              found;
  logic [2:0]        win;
  logic              hold;

  // Rotate req so ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[7:0];
    off   = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        off   = 3'(i);
        found = 1'b1;
      end
    end
    win = ptr + off;
  end

  assign hold = req[sel] && (cnt < LAST);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = 8'b1 << win;
          sel_n   = win;
          ptr_n   = win + 3'd1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_n = cnt + 1'b1;
        end else begin
          done_n = req[sel];
          cnt_n  = '0;
          if (found) begin
            gnt_n = 8'b1 << win;
            sel_n = win;
            ptr_n = win + 3'd1;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      sel        <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      gnt        <= gnt_n;
      sel        <= sel_n;
      burst_done <= done_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: MAX_BURST=4 instance plus a
// MAX_BURST=1 instance for the rotate-every-cycle case.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;

  logic [7:0] gnt, gnt1;
  logic [2:0] sel, sel1;
  logic       vld, vld1;
  logic       done, done1;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .sel        (sel),
    .gnt_valid  (vld),
    .burst_done (done)
  );

  mux8_rr_arbiter #(.MAX_BURST(1), .CNT_W(4)) u_one (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt1),
    .sel        (sel1),
    .gnt_valid  (vld1),
    .burst_done (done1)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  logic [2:0] s2 [9] = '{0, 0, 0, 0, 7, 7, 7, 7, 0};
  logic       d2 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    // Test 1: reset state and single short request
    do_reset();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", {5'd0, sel}, 8'd0);
    chk("rst_vld", {7'd0, vld}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    req = 8'b0000_0100;
    step();
    chk("t1_gnt", gnt, 8'b0000_0100);
    chk("t1_sel", {5'd0, sel}, 8'd2);
    chk("t1_vld", {7'd0, vld}, 8'd1);
    step();
    chk("t1_hold", gnt, 8'b0000_0100);
    req = '0;
    step();
    chk("t1_idle_gnt", gnt, 8'h00);
    chk("t1_idle_vld", {7'd0, vld}, 8'd0);
    chk("t1_idle_sel", {5'd0, sel}, 8'd2);

    // Test 2: two requesters alternate in bursts of 4
    do_reset();
    req = 8'b1000_0001;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t2_sel%0d", i), {5'd0, sel}, {5'd0, s2[i]});
      chk($sformatf("t2_done%0d", i), {7'd0, done}, {7'd0, d2[i]});
      chk($sformatf("t2_gnt%0d", i), gnt, 8'b1 << s2[i]);
    end

    // Test 3: MAX_BURST=1 rotates every cycle
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3_sel%0d", i), {5'd0, sel1}, 8'(i % 8));
      chk($sformatf("t3_vld%0d", i), {7'd0, vld1}, 8'd1);
      chk($sformatf("t3_done%0d", i), {7'd0, done1}, (i > 0) ? 8'd1 : 8'd0);
    end

    // Test 4: voluntary release hands over with no bubble
    do_reset();
    req = 8'b0000_1000;
    step();
    chk("t4_own", {5'd0, sel}, 8'd3);
    req = 8'b0010_0010;
    step();
    chk("t4_sel", {5'd0, sel}, 8'd5);
    chk("t4_gnt", gnt, 8'b0010_0000);
    chk("t4_done", {7'd0, done}, 8'd0);

    // Test 5: sole requester gets fresh bursts, done pulses each time
    do_reset();
    req = 8'b0100_0000;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t5_gnt%0d", i), gnt, 8'b0100_0000);
      chk($sformatf("t5_done%0d", i), {7'd0, done},
          (i == 5 || i == 9) ? 8'd1 : 8'd0);
    end

    // Test 6: reset mid-grant wins over everything
    do_reset();
    req = 8'b0010_0000;
    step();
    step();
    step();
    chk("t6_pre", {5'd0, sel}, 8'd5);
    req = 8'hFF;
    rst = 1'b1;
    step();
    chk("t6_gnt", gnt, 8'h00);
    chk("t6_sel", {5'd0, sel}, 8'd0);
    chk("t6_vld", {7'd0, vld}, 8'd0);
    chk("t6_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    step();
    chk("t6_regrant", gnt, 8'b0000_0001);
    chk("t6_sel0", {5'd0, sel}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8-to-1 multiplexer between 8 requesters. It grants one requester at a time and drives the mux select lines with a registered 3-bit select, so the granted input reaches the mux output Y. Grant hold time is capped per burst, so no requester can monopolise the mux. It sits directly in front of the mux8to1 select inputs: S2=sel[2], S1=sel[1], S0=sel[0].

Parameters:
MAX_BURST, 4, maximum consecutive cycles one owner may hold the grant (legal range 1..15).
CNT_W, 4, width of the internal burst counter (must hold MAX_BURST-1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
req  input  8  request vector; req[i]=1 means requester i wants mux input Ii.
gnt  output 8  one-hot grant, registered; all zeros when idle.
sel  output 3  mux select (index of the current owner), registered.
gnt_valid  output 1  1 when any grant is active (equals OR of gnt).
burst_done  output 1  one-cycle pulse, registered; asserted on the first cycle after a grant was forcibly ended by MAX_BURST.

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, sel=0, gnt_valid=0, burst_done=0, state=IDLE, priority pointer ptr=0, burst_cnt=0. Reset overrides all other activity, including mid-grant.
- Internal state: IDLE, GRANT. The 3-bit ptr names the highest-priority index. Search order is ptr, ptr+1, ..., ptr+7, taken mod 8 (wrap 7->0).
- Latency: a request sampled at edge t gives gnt, sel and gnt_valid valid after edge t (1-cycle latency). There is no combinational path from req to outputs.
- IDLE:
  - If req==0, stay in IDLE; gnt stays 0 and sel holds its last value.
  - Otherwise the winner w is the first set bit in search order. At the edge: gnt=onehot(w), sel=w, ptr=w+1 mod 8, burst_cnt=0, state=GRANT.
- GRANT (owner o = sel):
  - Hold: if req[o]=1 and burst_cnt < MAX_BURST-1, keep the grant and increment burst_cnt.
  - Release occurs when req[o]=0 (voluntary) or when burst_cnt == MAX_BURST-1 with req[o]=1 (forced).
  - On release, arbitrate again among the current req using the already-updated ptr (o+1). On a voluntary release, req[o] is already 0.
  - If a winner exists, grant it at the same edge with no bubble cycle, reset burst_cnt to 0, set ptr=winner+1, and stay in GRANT.
  - If no winner exists, set gnt=0 and go to IDLE. sel holds its value.
  - A forced-release owner can win again only if it is the sole requester. It then gets a fresh burst, and burst_done still pulses.
- burst_done: set to 1 at the edge of a forced release; otherwise 0.
- MAX_BURST=1: the grant rotates every cycle among active requesters.
- Simultaneous events:
  - A new req arriving on the release cycle takes part in that cycle's arbitration.
  - Requests from non-owners during a hold are ignored until release.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]==gnt_valid.
  - A continuously asserted req is granted within 7*MAX_BURST cycles of its first sampled edge.

Test Plan:
1. Reset, then req=8'b0000_0100 held 2 cycles, then 0 -> after first edge gnt=0000_0100, sel=2, gnt_valid=1; after the edge sampling req=0, gnt=0, gnt_valid=0, sel stays 2.
2. Reset, then req=8'b1000_0001 held; MAX_BURST=4 -> I0 granted for 4 cycles, burst_done pulses, I7 granted 4 cycles, burst_done pulses, I0 again. sel sequence is 0,0,0,0,7,7,7,7,0...
3. Reset, req=8'hFF held; MAX_BURST=1 -> sel steps 0,1,2,...,7,0 one per cycle; burst_done=1 on every cycle after the first grant; no idle gap.
4. Owner I3 granted (sel=3); I3 drops req while req[5]=1 and req[1]=1 -> next edge sel=5 (search starts at 4), gnt=0010_0000, no bubble, burst_done=0.
5. Sole requester I6 held for 10 cycles, MAX_BURST=4 -> gnt stays 0100_0000 throughout; burst_done pulses after cycles 4 and 8 of the grant.
6. Mid-grant (sel=5, burst_cnt=2) assert rst for one edge with req=8'hFF -> after that edge all outputs are 0 and ptr=0. On the next edge I0 is granted (sel=0).
